// File: rtl/therm_dac_dwa.sv
// ============================================================================
// Module   : therm_dac_dwa
// Brief    : Binary-to-thermometer unit-element driver with rotating DWA
//            pointer and a one-hot calibration walk. Rotation is enabled by
//            defining THERM_DAC_DWA_EN; otherwise a low-aligned thermometer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module therm_dac_dwa #(
  parameter int N        = 4,
  parameter int CAL_HOLD = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                code_valid,
  input  logic [N-1:0]        code,
  input  logic                cal_start,
  output logic [(2**N)-2:0]   sel,
  output logic                sel_valid,
  output logic                busy,
  output logic [N-1:0]        ptr
);

  localparam int         ELEM     = (2**N) - 1;
  localparam logic [7:0] CNT_LAST = 8'(CAL_HOLD - 1);
  localparam logic [N-1:0] IDX_LAST = N'(ELEM - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_CAL  = 2'd2
  } state_t;

  state_t            state_q,     state_d;
  logic [ELEM-1:0]   sel_q,       sel_d;
  logic              sel_valid_q, sel_valid_d;
  logic              busy_q,      busy_d;
  logic [N-1:0]      ptr_q,       ptr_d;
  logic [N-1:0]      cal_idx_q,   cal_idx_d;
  logic [7:0]        cal_cnt_q,   cal_cnt_d;

  logic [ELEM-1:0]   w_therm;
  logic [ELEM-1:0]   w_sel_map;
  logic [N-1:0]      w_ptr_map;

  // ELEM is the largest N-bit value, so no code can exceed it and no
  // saturation stage is needed.
  for (genvar i = 0; i < ELEM; i++) begin : g_therm
    assign w_therm[i] = ({1'b0, code} > (N+1)'(i));
  end

`ifdef THERM_DAC_DWA_EN
  logic [2*ELEM-1:0] w_rot;
  logic [N:0]        w_sum;

  // Rotate by folding the upper half of a double-width shift back onto bit 0.
  assign w_rot     = {{ELEM{1'b0}}, w_therm} << ptr_q;
  assign w_sel_map = w_rot[ELEM-1:0] | w_rot[2*ELEM-1:ELEM];
  assign w_sum     = {1'b0, ptr_q} + {1'b0, code};
  assign w_ptr_map = (w_sum >= (N+1)'(ELEM)) ? N'(w_sum - (N+1)'(ELEM))
                                             : w_sum[N-1:0];
`else
  assign w_sel_map = w_therm;
  assign w_ptr_map = '0;
`endif

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    sel_valid_d = 1'b0;
    busy_d      = busy_q;
    ptr_d       = ptr_q;
    cal_idx_d   = cal_idx_q;
    cal_cnt_d   = cal_cnt_q;
    case (state_q)
      S_IDLE, S_RUN: begin
        if (cal_start) begin
          state_d     = S_CAL;
          sel_d       = {{(ELEM-1){1'b0}}, 1'b1};
          sel_valid_d = 1'b1;
          busy_d      = 1'b1;
          cal_idx_d   = '0;
          cal_cnt_d   = '0;
        end else if (code_valid) begin
          state_d     = S_RUN;
          sel_d       = w_sel_map;
          ptr_d       = w_ptr_map;
          sel_valid_d = 1'b1;
        end
      end
      S_CAL: begin
        if (cal_cnt_q == CNT_LAST) begin
          cal_cnt_d = '0;
          if (cal_idx_q == IDX_LAST) begin
            state_d = S_IDLE;
            sel_d   = '0;
            busy_d  = 1'b0;
            ptr_d   = '0;
          end else begin
            cal_idx_d   = cal_idx_q + 1'b1;
            sel_d       = {sel_q[ELEM-2:0], 1'b0};
            sel_valid_d = 1'b1;
          end
        end else begin
          cal_cnt_d = cal_cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      sel_q       <= '0;
      sel_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      ptr_q       <= '0;
      cal_idx_q   <= '0;
      cal_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      sel_valid_q <= sel_valid_d;
      busy_q      <= busy_d;
      ptr_q       <= ptr_d;
      cal_idx_q   <= cal_idx_d;
      cal_cnt_q   <= cal_cnt_d;
    end
  end

  assign sel       = sel_q;
  assign sel_valid = sel_valid_q;
  assign busy      = busy_q;
  assign ptr       = ptr_q;

endmodule

`default_nettype wire
